// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes, one-entry output
// register, {Z,N,C,V} flags, persistent carry for ADC and an iterative
// shift-add unsigned multiplier (one multiplier bit per clock).
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_FLIP = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_LSL  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  logic             r_c;
  logic             r_busy;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [SHW-1:0]   r_cnt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_cin;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [PW-1:0]    w_acc_nxt;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_prod_lo;

  assign in_ready   = !r_busy && (!out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (alu_sel == OP_MUL);
  assign w_cin      = (alu_sel == OP_ADC) & r_c;
  assign w_shamt    = in2[SHW-1:0];
  assign w_add      = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub      = {1'b0, in1} - {1'b0, in2};
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});
  assign w_mul_done = r_busy && (r_cnt == SHW'(WIDTH - 1));
  assign w_prod_lo  = w_acc_nxt[WIDTH-1:0];

  // Single-cycle result and C/V for opcodes 0-8; MUL and 10-15 give zero
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (alu_sel)
      OP_ADD, OP_ADC: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_add[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_sub[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  w_res = in1 & in2;
      OP_OR:   w_res = in1 | in2;
      OP_XOR:  w_res = in1 ^ in2;
      OP_FLIP: w_res = in1 ^ (WIDTH'(1) << w_shamt);
      OP_LSR:  w_res = in1 >> w_shamt;
      OP_LSL:  w_res = in1 << w_shamt;
      default: w_res = '0;
    endcase
  end

  // Output register, flags and carry register; loads on single-cycle accept or MUL completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      flags     <= '0;
      r_c       <= 1'b0;
    end else if (w_mul_done) begin
      out_valid <= 1'b1;
      alu_out   <= w_prod_lo;
      flags     <= {(w_prod_lo == '0), w_prod_lo[WIDTH-1], 1'b0, |w_acc_nxt[PW-1:WIDTH]};
      r_c       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      out_valid <= 1'b1;
      alu_out   <= w_res;
      flags     <= {(w_res == '0), w_res[WIDTH-1], w_c, w_v};
      r_c       <= w_c;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Iterative shift-add multiplier: WIDTH steps, last step writes the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_busy   <= 1'b1;
      r_mcand  <= {{WIDTH{1'b0}}, in1};
      r_mplier <= in2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
      if (w_mul_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors plus hand-written multi-cycle sequences for alu_pipe.
module tb_alu_pipe;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  fl;   // {Z,N,C,V}
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    alu_sel  = op;
    in1      = a;
    in2      = b;
  endtask

  // MUL: in_ready low and out_valid low for WIDTH cycles, result exactly WIDTH edges after accept
  task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic [3:0] exp_fl);
    @(negedge clk);
    drive(4'd9, a, b);
    check({name, "_rdy0"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < int'(WIDTH); i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("%s_busy_rdy%0d", name, i), 32'(in_ready), 32'd0);
      check($sformatf("%s_busy_vld%0d", name, i), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({name, "_vld"}, 32'(out_valid), 32'd1);
    check({name, "_res"}, 32'(alu_out), 32'(exp_res));
    check({name, "_flg"}, 32'(flags), 32'(exp_fl));
  endtask

  initial begin
    vecs[0]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
    vecs[1]  = '{4'd8,  16'h0001, 16'h0001, 16'h0003, 4'b0000};
    vecs[2]  = '{4'd8,  16'h0001, 16'h0001, 16'h0002, 4'b0000};
    vecs[3]  = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
    vecs[4]  = '{4'd1,  16'h0001, 16'h0002, 16'hFFFF, 4'b0110};
    vecs[5]  = '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    vecs[6]  = '{4'd8,  16'h0001, 16'h0001, 16'h0002, 4'b0000};
    vecs[7]  = '{4'd3,  16'h1200, 16'h0034, 16'h1234, 4'b0000};
    vecs[8]  = '{4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000};
    vecs[9]  = '{4'd5,  16'h00F0, 16'h0014, 16'h00E0, 4'b0000};
    vecs[10] = '{4'd6,  16'h8000, 16'h00FF, 16'h0001, 4'b0000};
    vecs[11] = '{4'd7,  16'h0001, 16'h001F, 16'h8000, 4'b0100};
    vecs[12] = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
    vecs[13] = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 4'b1000};
    vecs[14] = '{4'd1,  16'h0005, 16'h0005, 16'h0000, 4'b1000};
    vecs[15] = '{4'd0,  16'h8000, 16'h8000, 16'h0000, 4'b1011};
    vecs[16] = '{4'd8,  16'h0000, 16'h0000, 16'h0001, 4'b0000};
    vecs[17] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000};
    vecs[18] = '{4'd0,  16'h0005, 16'h0003, 16'h0008, 4'b0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_sel   = 4'd0;
    in1       = '0;
    in2       = '0;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_out", 32'(alu_out), 32'd0);
    check("rst_flg", 32'(flags), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 32'(in_ready), 32'd1);

    // Table-driven single-cycle ops, latency 1
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_vld", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_res", i), 32'(alu_out), 32'(vecs[i].res));
      check($sformatf("vec%0d_flg", i), 32'(flags), 32'(vecs[i].fl));
    end
    @(negedge clk);
    check("drain_vld", 32'(out_valid), 32'd0);

    // Back-to-back: one accept and one result per clock
    drive(4'd0, 16'h0001, 16'h0001);
    @(negedge clk);
    check("b2b0_res", 32'(alu_out), 32'h0002);
    drive(4'd4, 16'h00FF, 16'h0F0F);
    check("b2b1_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("b2b1_vld", 32'(out_valid), 32'd1);
    check("b2b1_res", 32'(alu_out), 32'h0FF0);
    drive(4'd3, 16'h0100, 16'h0001);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b2_vld", 32'(out_valid), 32'd1);
    check("b2b2_res", 32'(alu_out), 32'h0101);

    // MUL with an ADD held at the input throughout: must wait, then follow without a bubble
    @(negedge clk);
    drive(4'd9, 16'h0100, 16'h0100);
    check("mulA_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(4'd0, 16'h0002, 16'h0003);
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      check($sformatf("mulA_busy_rdy%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("mulA_busy_vld%0d", i), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    check("mulA_last_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("mulA_vld", 32'(out_valid), 32'd1);
    check("mulA_res", 32'(alu_out), 32'h0000);
    check("mulA_flg", 32'(flags), 32'b1001);
    check("mulA_rdy_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("mulA_next_vld", 32'(out_valid), 32'd1);
    check("mulA_next_res", 32'(alu_out), 32'h0005);
    check("mulA_next_flg", 32'(flags), 32'b0000);

    run_mul("mulB", 16'h0003, 16'h0005, 16'h000F, 4'b0000);
    run_mul("mulC", 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001);

    // MUL clears the carry register
    @(negedge clk);
    drive(4'd8, 16'h0001, 16'h0001);
    @(negedge clk);
    in_valid = 1'b0;
    check("mul_c_clr", 32'(alu_out), 32'h0002);

    // Output hold under back-pressure
    @(negedge clk);
    drive(4'd0, 16'h0010, 16'h0020);
    @(negedge clk);
    check("hold_first", 32'(alu_out), 32'h0030);
    out_ready = 1'b0;
    drive(4'd0, 16'h0001, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold%0d_rdy", i), 32'(in_ready), 32'd0);
      @(negedge clk);
      check($sformatf("hold%0d_vld", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_res", i), 32'(alu_out), 32'h0030);
      check($sformatf("hold%0d_flg", i), 32'(flags), 32'b0000);
    end
    out_ready = 1'b1;
    #1;
    check("hold_release_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_next_vld", 32'(out_valid), 32'd1);
    check("hold_next_res", 32'(alu_out), 32'h0002);
    @(negedge clk);
    check("hold_drain_vld", 32'(out_valid), 32'd0);

    // Reset during MUL: outputs clear at once, iteration abandoned
    drive(4'd1, 16'h0001, 16'h0002);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_res", 32'(alu_out), 32'hFFFF);
    @(negedge clk);
    drive(4'd9, 16'h0007, 16'h0009);
    repeat (7) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("mid_mul_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_vld", 32'(out_valid), 32'd0);
    check("arst_res", 32'(alu_out), 32'd0);
    check("arst_flg", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < int'(WIDTH) + 2; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'd0);
    end
    drive(4'd0, 16'h0004, 16'h0005);
    check("post_rst_rdy2", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_vld", 32'(out_valid), 32'd1);
    check("post_rst_res", 32'(alu_out), 32'h0009);
    check("post_rst_flg", 32'(flags), 32'b0000);
    @(negedge clk);
    check("post_rst_drain", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 16-bit combinational ALU. Adds valid/ready handshakes on input and output, a one-entry output register, and a flag output (zero/negative/carry/overflow). Adds a persistent carry register for add-with-carry and an iterative multi-cycle unsigned multiply. Sits between the register-file read stage and writeback in the datapath.

Parameters:
- WIDTH, 16: operand/result width in bits; any value ≥4; power of two required.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block accepts operands this cycle
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- alu_sel  in  4  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- alu_out  out  WIDTH  result
- flags  out  4  {Z, N, C, V}

Behaviour:
- Opcodes (alu_sel):
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 FLIP: in1 ^ (1 << in2[SHW-1:0]).
  - 6 LSR and 7 LSL, logical, amount in2[SHW-1:0].
  - 8 ADC: in1+in2+c_reg.
  - 9 MUL: low WIDTH bits of unsigned in1*in2.
  - 10–15: result 0, flags Z=1, others 0.
- Accept occurs when in_valid && in_ready.
- in_ready = !busy && (!out_valid || out_ready). Back-to-back single-cycle ops are sustained at one per clock when out_ready=1.
- Single-cycle ops (0–8): result and flags registered on the accept edge; out_valid=1 in the next cycle (latency 1).
- MUL:
  - Accept loads the iterative shift-add unit; busy=1.
  - One multiplier bit is processed per clock. Result is registered and out_valid rises exactly WIDTH cycles after the accept edge.
  - in_ready=0 throughout.
  - busy clears when the result is written to the output register.
- Output hold: while out_valid && !out_ready, alu_out and flags remain stable and nothing is accepted.
- out_valid drops the cycle after out_valid && out_ready, unless a new accept occurred on that same edge (then the new result is presented, out_valid stays 1).
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - C for ADD/ADC: carry-out. C for SUB: borrow (in1 < in2 unsigned).
  - V for ADD/ADC/SUB: signed overflow.
  - MUL: C=0; V=1 if the upper WIDTH bits of the full 2*WIDTH product are nonzero.
  - All other ops: C=0, V=0.
- c_reg:
  - Updated to flag C on every op's completion (the edge the result is registered); ADC reads the value present at accept.
  - Not affected by stalls.
- Width rule: all arithmetic is modulo 2^WIDTH; the shift amount uses only the low SHW bits of in2; upper in2 bits are ignored for 5/6/7.
- Reset (async, any time, including mid-MUL):
  - out_valid=0, alu_out=0, flags=0, c_reg=0, busy=0.
  - The multiplier iteration is abandoned.
  - in_ready=1 in the first cycle after rst_n deasserts.
- Inputs are ignored when in_valid=0 or in_ready=0. in1, in2 and alu_sel need only be stable on the accept edge.

Test Plan:
- WIDTH=16, out_ready=1, ADD 0xFFFF+0x0001 -> next cycle alu_out=0x0000, flags Z=1 C=1 N=0 V=0. Then ADC 0x0001+0x0001 -> alu_out=0x0003, c_reg cleared.
- SUB 0x8000-0x0001 -> alu_out=0x7FFF, V=1, C=0. SUB 0x0001-0x0002 -> 0xFFFF, N=1, C=1.
- FLIP in1=0x00F0, in2=0x0014 (amount 4) -> 0x00E0. LSL 0x0001 by 0x001F (amount 15) -> 0x8000, N=1.
- MUL 0x0100*0x0100 -> in_ready low for 16 cycles, out_valid exactly 16 cycles after accept, alu_out=0x0000, Z=1, V=1. MUL 0x0003*0x0005 -> 0x000F, V=0.
- Hold out_ready=0 for 5 cycles after an ADD result -> alu_out/flags stable, in_ready=0, no new accept. Raise out_ready with in_valid high -> next result on the following cycle with no bubble.
- Assert rst_n=0 in cycle 7 of a MUL -> all outputs 0 immediately. After release: in_ready=1, a single ADD completes with latency 1.
